// File: rtl/multi_ch_dispatcher.sv
// multi_ch_dispatcher: per-channel FIFOs drained packet-atomically by a round-robin arbiter onto one AXI-Stream port
module multi_ch_dispatcher #(
  parameter int DATAW = 512,
  parameter int USERW = 75,
  parameter int BYTEW = 8,
  parameter int IDW = 32,
  parameter int DESTW = 7,
  parameter int NUM_CH = 4,
  parameter int DEPTH = 512,
  parameter int PKT_LEN = 8,
  parameter int AF_MARGIN = 4,
  parameter int DEST_BASE = 0,
  parameter logic [USERW-1:0] USER_HDR = 'h400,
  localparam int DATAUSERW = DATAW + USERW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           in_wen,
  input  logic [NUM_CH*DATAW-1:0]     in_wdata,
  output logic [NUM_CH-1:0]           in_rdy,
  output logic [NUM_CH-1:0]           in_ovf,
  output logic                        axis_tx_tvalid,
  input  logic                        axis_tx_tready,
  output logic [DATAUSERW-1:0]        axis_tx_tdata,
  output logic [BYTEW-1:0]            axis_tx_tstrb,
  output logic [BYTEW-1:0]            axis_tx_tkeep,
  output logic [IDW-1:0]              axis_tx_tid,
  output logic [DESTW-1:0]            axis_tx_tdest,
  output logic [USERW-1:0]            axis_tx_tuser,
  output logic                        axis_tx_tlast
);
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [DATAW-1:0] mem [NUM_CH][DEPTH];
  logic [PW-1:0] wr_ptr [NUM_CH];
  logic [PW-1:0] rd_ptr [NUM_CH];
  logic [CW-1:0] count [NUM_CH];
  logic [NUM_CH-1:0] elig, push, pop;
  logic [CHW-1:0] cur, last_grant, winner;
  logic [BW-1:0] beat;
  logic any_elig, load, last_beat;
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = count[i] >= CW'(PKT_LEN);
      in_rdy[i] = count[i] < CW'(DEPTH - AF_MARGIN);
      push[i] = in_wen[i] && count[i] != CW'(DEPTH);
      pop[i] = load && cur == CHW'(i);
    end
  end
  // descending scan so the closest channel after last_grant is written last and wins
  always_comb begin
    winner = '0;
    any_elig = 1'b0;
    for (int i = NUM_CH; i >= 1; i--)
      if (elig[(int'(last_grant) + i) % NUM_CH]) begin
        any_elig = 1'b1;
        winner = CHW'((int'(last_grant) + i) % NUM_CH);
      end
  end
  assign load = state == SEND && (!axis_tx_tvalid || axis_tx_tready);
  assign last_beat = beat == BW'(PKT_LEN - 1);
  always_comb state_nx = state == IDLE ? (any_elig ? SEND : IDLE) : (load && last_beat ? IDLE : SEND);
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= in_wdata[i*DATAW +: DATAW];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i] <= '0;
      end
      in_ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] == PW'(DEPTH - 1) ? '0 : wr_ptr[i] + 1'b1;
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] == PW'(DEPTH - 1) ? '0 : rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
        if (in_wen[i] && !push[i]) in_ovf[i] <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= '0;
      last_grant <= CHW'(NUM_CH - 1);
      beat <= '0;
      axis_tx_tvalid <= 1'b0;
      axis_tx_tlast <= 1'b0;
      axis_tx_tdata <= '0;
      axis_tx_tid <= '0;
      axis_tx_tdest <= '0;
    end else begin
      if (state == IDLE && any_elig) begin
        cur <= winner;
        last_grant <= winner;
        beat <= '0;
      end
      if (load) begin
        axis_tx_tvalid <= 1'b1;
        axis_tx_tdata <= {USER_HDR, mem[cur][rd_ptr[cur]]};
        axis_tx_tid <= IDW'(cur);
        axis_tx_tdest <= DESTW'(DEST_BASE + int'(cur));
        axis_tx_tlast <= last_beat;
        beat <= beat + 1'b1;
      end else if (axis_tx_tready) axis_tx_tvalid <= 1'b0;
    end
  end
  assign axis_tx_tstrb = axis_tx_tvalid ? '1 : '0;
  assign axis_tx_tkeep = axis_tx_tvalid ? '1 : '0;
  assign axis_tx_tuser = axis_tx_tvalid ? USER_HDR : '0;
endmodule

// File: tb/tb_multi_ch_dispatcher.sv
// tb_multi_ch_dispatcher: directed tables, corner sequences and random traffic against a queue-based reference model
module tb_multi_ch_dispatcher;
  localparam int DATAW = 512, USERW = 75, BYTEW = 8, IDW = 32, DESTW = 7;
  localparam int NUM_CH = 4, DEPTH = 512, PKT_LEN = 8, AF_MARGIN = 4, DEST_BASE = 0;
  localparam logic [USERW-1:0] HDR = 'h400;
  localparam int DUW = DATAW + USERW;
  logic clk = 0, rst = 1;
  logic [NUM_CH-1:0] in_wen = '0, in_rdy, in_ovf;
  logic [NUM_CH*DATAW-1:0] in_wdata = '0;
  logic tvalid, tready = 1, tlast;
  logic [DUW-1:0] tdata;
  logic [BYTEW-1:0] tstrb, tkeep;
  logic [IDW-1:0] tid;
  logic [DESTW-1:0] tdest;
  logic [USERW-1:0] tuser;
  multi_ch_dispatcher #(.DATAW(DATAW), .USERW(USERW), .BYTEW(BYTEW), .IDW(IDW), .DESTW(DESTW),
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN), .AF_MARGIN(AF_MARGIN), .DEST_BASE(DEST_BASE),
    .USER_HDR(HDR)) dut (
    .clk(clk), .rst(rst), .in_wen(in_wen), .in_wdata(in_wdata), .in_rdy(in_rdy), .in_ovf(in_ovf),
    .axis_tx_tvalid(tvalid), .axis_tx_tready(tready), .axis_tx_tdata(tdata), .axis_tx_tstrb(tstrb),
    .axis_tx_tkeep(tkeep), .axis_tx_tid(tid), .axis_tx_tdest(tdest), .axis_tx_tuser(tuser),
    .axis_tx_tlast(tlast));
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0, hs = 0;
  task automatic chk(input string name, input logic [DUW-1:0] got, input logic [DUW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  // reference model: per-channel queues plus a packet-level round-robin scheduler
  logic [DATAW-1:0] mq [NUM_CH][$];
  logic [NUM_CH-1:0] m_ovf;
  logic [DATAW-1:0] m_pay;
  bit m_busy, m_valid, m_last;
  int m_cur, m_tid, m_sent, m_lastg;
  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    m_ovf = '0; m_busy = 0; m_valid = 0; m_last = 0;
    m_cur = 0; m_tid = 0; m_sent = 0; m_lastg = NUM_CH - 1; m_pay = '0;
  endtask
  task automatic m_step();
    int sz [NUM_CH];
    for (int c = 0; c < NUM_CH; c++) sz[c] = mq[c].size();
    if (m_busy && (!m_valid || tready)) begin
      m_pay = mq[m_cur].pop_front();
      m_valid = 1; m_tid = m_cur;
      m_last = m_sent == PKT_LEN - 1;
      m_sent++;
      if (m_last) m_busy = 0;
    end else begin
      if (tready) m_valid = 0;
      for (int k = 1; k <= NUM_CH; k++)
        if (!m_busy && sz[(m_lastg + k) % NUM_CH] >= PKT_LEN) begin
          m_cur = (m_lastg + k) % NUM_CH; m_lastg = m_cur; m_busy = 1; m_sent = 0;
        end
    end
    for (int c = 0; c < NUM_CH; c++)
      if (in_wen[c]) begin
        if (sz[c] < DEPTH) mq[c].push_back(in_wdata[c*DATAW +: DATAW]);
        else m_ovf[c] = 1;
      end
  endtask
  task automatic m_check();
    logic [NUM_CH-1:0] er;
    for (int c = 0; c < NUM_CH; c++) er[c] = mq[c].size() < DEPTH - AF_MARGIN;
    chk("tvalid", tvalid, m_valid);
    if (m_valid) begin
      chk("tdata", tdata, {HDR, m_pay});
      chk("tid", tid, m_tid);
      chk("tdest", tdest, DESTW'(DEST_BASE + m_tid));
      chk("tlast", tlast, m_last);
      chk("tkeep", tkeep, {BYTEW{1'b1}});
      chk("tstrb", tstrb, {BYTEW{1'b1}});
      chk("tuser", tuser, HDR);
    end else begin
      chk("tkeep_idle", tkeep, 0);
      chk("tstrb_idle", tstrb, 0);
      chk("tuser_idle", tuser, 0);
    end
    chk("in_rdy", in_rdy, er);
    chk("in_ovf", in_ovf, m_ovf);
  endtask
  task automatic step();
    if (tvalid && tready) hs++;
    m_step();
    @(posedge clk);
    #1;
    m_check();
  endtask
  task automatic push_ch(input int c, input int v);
    in_wen = NUM_CH'(1) << c;
    in_wdata[c*DATAW +: DATAW] = DATAW'(v);
    step();
    in_wen = '0;
  endtask
  task automatic drain(input string nm);
    int n = 0;
    bit more = 1;
    in_wen = '0; tready = 1;
    while (more && n < 3000) begin
      step(); n++;
      more = m_busy || m_valid;
      for (int c = 0; c < NUM_CH; c++) if (mq[c].size() >= PKT_LEN) more = 1;
    end
    chk(nm, n < 3000, 1);
  endtask
  task automatic pulse_rst();
    rst = 1; #1; rst = 0; m_reset();
  endtask
  typedef struct {
    logic [NUM_CH-1:0] wen;
    int val;
    logic ev;
    int pay;
    logic el;
  } vec_t;
  vec_t tbl [18];
  initial begin
    int starts [4], tids [4], np, seen;
    bit prev;
    for (int i = 0; i < 18; i++) begin
      tbl[i].wen = i < 8 ? 4'b0100 : 4'b0000;
      tbl[i].val = i < 8 ? i : 0;
      tbl[i].ev = i >= 9 && i <= 16;
      tbl[i].pay = i - 9;
      tbl[i].el = i == 16;
    end
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tid", tid, 0);
    chk("rst_tdest", tdest, 0);
    chk("rst_in_rdy", in_rdy, 4'hf);
    chk("rst_in_ovf", in_ovf, 0);
    rst = 0;
    // single ch2 packet, exact cycle timing
    for (int i = 0; i < 18; i++) begin
      in_wen = tbl[i].wen;
      in_wdata[2*DATAW +: DATAW] = DATAW'(tbl[i].val);
      step();
      chk("tbl_valid", tvalid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("tbl_data", tdata, {HDR, DATAW'(tbl[i].pay)});
        chk("tbl_tid", tid, 2);
        chk("tbl_tdest", tdest, DEST_BASE + 2);
        chk("tbl_tlast", tlast, tbl[i].el);
      end
    end
    in_wen = '0;
    // backpressure during a packet
    hs = 0;
    for (int i = 0; i < 8; i++) push_ch(0, 100 + i);
    step();
    step();
    chk("bp_first", tdata[DATAW-1:0], 100);
    step();
    chk("bp_second", tdata[DATAW-1:0], 101);
    tready = 0;
    step(); chk("bp_freeze0", tdata[DATAW-1:0], 101);
    step(); chk("bp_freeze1", tdata[DATAW-1:0], 101);
    chk("bp_freeze_valid", tvalid, 1);
    tready = 1;
    step(); chk("bp_resume", tdata[DATAW-1:0], 102);
    repeat (10) step();
    chk("bp_beats", hs, 8);
    // all four channels full at once, round-robin from ch0
    pulse_rst();
    in_wen = '1;
    np = 0; prev = 0;
    for (int j = 0; j < 60; j++) begin
      if (j == 8) in_wen = '0;
      for (int c = 0; c < NUM_CH; c++) in_wdata[c*DATAW +: DATAW] = DATAW'(c * 16 + j);
      step();
      if (tvalid && !prev && np < 4) begin starts[np] = j; tids[np] = int'(tid); np++; end
      prev = tvalid;
    end
    chk("rr_npkts", np, 4);
    for (int k = 0; k < 4; k++) begin
      chk("rr_order", tids[k], k);
      chk("rr_start", starts[k], 9 + 9 * k);
    end
    // seven words do not qualify; the eighth starts a packet two edges later
    for (int i = 0; i < 7; i++) push_ch(3, 200 + i);
    repeat (10) begin step(); chk("short_nogrant", tvalid, 0); end
    push_ch(3, 207);
    chk("ch3_n", tvalid, 0);
    step(); chk("ch3_n1", tvalid, 0);
    step(); chk("ch3_n2", tvalid, 1);
    chk("ch3_tid", tid, 3);
    drain("drain_ch3");
    // fill ch1 past full with output stalled
    tready = 0;
    for (int k = 1; k <= DEPTH + 2; k++) begin
      push_ch(1, 1000 + k);
      if (k == 508) chk("af_rdy_508", in_rdy[1], 1);
      if (k == 509) chk("af_rdy_509", in_rdy[1], 0);
      if (k == 513) chk("full_no_ovf", in_ovf[1], 0);
      if (k == 514) chk("full_ovf", in_ovf[1], 1);
    end
    drain("drain_full");
    chk("drain_rdy", in_rdy, 4'hf);
    // reset mid-packet
    for (int i = 0; i < 8; i++) push_ch(0, i);
    repeat (5) step();
    chk("mid_beat3", tdata[DATAW-1:0], 3);
    #2 rst = 1;
    #1;
    chk("async_tvalid", tvalid, 0);
    chk("async_ovf", in_ovf, 0);
    chk("async_tdata", tdata, 0);
    @(posedge clk);
    #1 rst = 0;
    m_reset();
    seen = 0;
    repeat (20) begin step(); if (tvalid) seen++; end
    chk("post_rst_beats", seen, 0);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      in_wen = NUM_CH'($urandom & $urandom);
      for (int c = 0; c < NUM_CH; c++)
        for (int w = 0; w < DATAW / 32; w++) in_wdata[c*DATAW + w*32 +: 32] = $urandom;
      tready = ($urandom % 4) != 0;
      step();
    end
    drain("drain_rand");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
